// File: rtl/offnariscv_line_mem_if.sv
// ACE slave-side bundle for the line memory: AW/W/B/AR/R channels plus the idle snoop handshakes.
// Widths follow the memory's parameters; master drives requests, slave drives responses.
interface offnariscv_line_mem_if #(
    parameter int DATA_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 32,
    parameter int ACE_XID_WIDTH   = 4,
    parameter int ACE_AXLEN_WIDTH = 8,
    parameter int ACE_BRESP_WIDTH = 2,
    parameter int ACE_RRESP_WIDTH = 4
);
    logic [ACE_XID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0]      awaddr;
    logic [ACE_AXLEN_WIDTH-1:0] awlen;
    logic                       awvalid;
    logic                       awready;

    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    wstrb;
    logic                       wlast;
    logic                       wvalid;
    logic                       wready;

    logic [ACE_XID_WIDTH-1:0]   bid;
    logic [ACE_BRESP_WIDTH-1:0] bresp;
    logic                       bvalid;
    logic                       bready;

    logic [ACE_XID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0]      araddr;
    logic [ACE_AXLEN_WIDTH-1:0] arlen;
    logic                       arvalid;
    logic                       arready;

    logic [ACE_XID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [ACE_RRESP_WIDTH-1:0] rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    logic                       acvalid;
    logic                       crready;
    logic                       cdready;
    logic                       rack;
    logic                       wack;

    modport master (
        output awid, awaddr, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        input  acvalid, crready, cdready,
        output rack, wack
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        output acvalid, crready, cdready,
        input  rack, wack
    );
endinterface

// File: rtl/offnariscv_line_mem.sv
// Line-granular ACE slave memory: one 256-bit line read and one line write in flight; snoop channels idle.
// Latency: AR->R is 1+RD_LATENCY cycles, write commit->B is 1 cycle; one transaction per FSM at a time.
// Backpressure: R/B hold until rready/bready; AR/AW/W stall while busy. OFFNARISCV_LINEMEM_ERRRESP_EN enables SLVERR.
module offnariscv_line_mem #(
    parameter int DATA_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH_LINES     = 1024,
    parameter int RD_LATENCY      = 2,
    parameter int ACE_XID_WIDTH   = 4,
    parameter int ACE_AXLEN_WIDTH = 8,
    parameter int ACE_BRESP_WIDTH = 2,
    parameter int ACE_RRESP_WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    offnariscv_line_mem_if.slave ace
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LINE_W = ADDR_WIDTH - 5;
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    // The wait state is entered one cycle after AR, so it counts down from RD_LATENCY-1.
    localparam logic [3:0] LAT_LOAD = (RD_LATENCY == 0) ? 4'd0 : 4'(RD_LATENCY - 1);
    localparam logic [ACE_RRESP_WIDTH-1:0] R_OKAY  = '0;
    localparam logic [ACE_RRESP_WIDTH-1:0] R_SLVER = ACE_RRESP_WIDTH'(2'b10);
    localparam logic [ACE_BRESP_WIDTH-1:0] B_OKAY  = '0;
    localparam logic [ACE_BRESP_WIDTH-1:0] B_SLVER = ACE_BRESP_WIDTH'(2'b10);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_LINES];

    // ---------------- address decode ----------------
    logic [LINE_W-1:0] ar_line, aw_line;
    logic [IDX_W-1:0]  ar_idx, aw_idx;
    logic              ar_err, aw_err;

    assign ar_line = ace.araddr[ADDR_WIDTH-1:5];
    assign aw_line = ace.awaddr[ADDR_WIDTH-1:5];
    assign ar_idx  = ar_line[IDX_W-1:0];
    assign aw_idx  = aw_line[IDX_W-1:0];

`ifdef OFFNARISCV_LINEMEM_ERRRESP_EN
    assign ar_err = ({1'b0, ar_line} >= (LINE_W+1)'(DEPTH_LINES)) || (ace.arlen != '0);
    assign aw_err = ({1'b0, aw_line} >= (LINE_W+1)'(DEPTH_LINES)) || (ace.awlen != '0);
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    // ---------------- read path ----------------
    r_state_e                   r_state_q, r_state_d;
    logic [3:0]                 r_cnt_q, r_cnt_d;
    logic [ACE_XID_WIDTH-1:0]   rid_q, rid_d;
    logic [IDX_W-1:0]           ridx_q, ridx_d;
    logic                       rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [ACE_RRESP_WIDTH-1:0] rresp_q, rresp_d;

    logic                  ar_hs;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_line;

    assign ace.arready = !rst && (r_state_q == R_IDLE);
    assign ar_hs       = ace.arvalid && ace.arready;
    // With zero latency the array is sampled straight off the AR bus.
    assign rd_idx      = (r_state_q == R_IDLE) ? ar_idx : ridx_q;
    assign rd_err      = (r_state_q == R_IDLE) ? ar_err : rerr_q;
    assign rd_line     = mem_q[rd_idx];

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rerr_d    = rerr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d  = ace.arid;
                    ridx_d = ar_idx;
                    rerr_d = ar_err;
                    if (RD_LATENCY == 0) begin
                        rdata_d   = rd_err ? '0 : rd_line;
                        rresp_d   = rd_err ? R_SLVER : R_OKAY;
                        r_state_d = R_RESP;
                    end else begin
                        r_cnt_d   = LAT_LOAD;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    rdata_d   = rd_err ? '0 : rd_line;
                    rresp_d   = rd_err ? R_SLVER : R_OKAY;
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (ace.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            rid_q     <= '0;
            ridx_q    <= '0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign ace.rvalid = (r_state_q == R_RESP);
    assign ace.rlast  = (r_state_q == R_RESP);
    assign ace.rid    = rid_q;
    assign ace.rdata  = rdata_q;
    assign ace.rresp  = rresp_q;

    // ---------------- write path ----------------
    w_state_e                   w_state_q, w_state_d;
    logic                       aw_held_q, aw_held_d;
    logic                       w_held_q, w_held_d;
    logic [ACE_XID_WIDTH-1:0]   bid_q, bid_d;
    logic [IDX_W-1:0]           widx_q, widx_d;
    logic                       awerr_q, awerr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]          wstrb_q, wstrb_d;
    logic [ACE_BRESP_WIDTH-1:0] bresp_q, bresp_d;

    logic                  aw_hs, w_hs, commit;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_err;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_W-1:0]     cur_wstrb;
    logic                  mem_we;

    assign ace.awready = !rst && (w_state_q == W_IDLE) && !aw_held_q;
    assign ace.wready  = !rst && (w_state_q == W_IDLE) && !w_held_q;
    assign aw_hs       = ace.awvalid && ace.awready;
    assign w_hs        = ace.wvalid && ace.wready;

    // Whichever half arrives this cycle is taken from the bus, the other from its holding register.
    assign cur_idx   = aw_hs ? aw_idx : widx_q;
    assign cur_err   = aw_hs ? aw_err : awerr_q;
    assign cur_wdata = w_hs ? ace.wdata : wdata_q;
    assign cur_wstrb = w_hs ? ace.wstrb : wstrb_q;
    assign commit    = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign mem_we    = commit && !cur_err;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bid_d     = bid_q;
        widx_d    = widx_q;
        awerr_d   = awerr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            bid_d     = ace.awid;
            widx_d    = aw_idx;
            awerr_d   = aw_err;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = ace.wdata;
            wstrb_d  = ace.wstrb;
        end
        case (w_state_q)
            W_IDLE: begin
                if (commit) begin
                    bresp_d   = cur_err ? B_SLVER : B_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (ace.bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bid_q     <= '0;
            widx_q    <= '0;
            awerr_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            awerr_q   <= awerr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Array is deliberately left out of reset so committed lines survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cur_wstrb[b]) mem_q[cur_idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
            end
        end
    end

    assign ace.bvalid = (w_state_q == W_RESP);
    assign ace.bid    = bid_q;
    assign ace.bresp  = bresp_q;

    // ---------------- snoop channels ----------------
    assign ace.acvalid = 1'b0;
    assign ace.crready = 1'b1;
    assign ace.cdready = 1'b1;

    logic unused_sig;
    assign unused_sig = ^{ace.awaddr, ace.araddr, ace.awlen, ace.arlen, ace.wlast, ace.rack, ace.wack};

endmodule
